// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver.
//   PAR_NONE / PAR_ODD / PAR_EVEN : parity-mode selector values
//   rx_state_t                    : receiver FSM state encoding
//   clogb2                        : ceil(log2(value)), for sizing counters and pointers
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BRK    = 3'd5
  } rx_state_t;

  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through FIFO for received frames.
//   clk, rst        : clock, synchronous active-high reset
//   push, wr_data   : write request and entry
//   pop             : read request (ignored while empty)
//   rd_data         : head entry, driven straight from storage
//   full, empty     : status from extended-pointer compare
// A push while full is accepted only if a pop happens in the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = clogb2(DEPTH);

  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_wp == r_rp);
  assign full      = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign rd_data   = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wp[AW-1:0]] <= wr_data;
        r_wp <= r_wp + 1'b1;
      end
      if (w_do_pop) r_rp <= r_rp + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with majority-vote sampling and an output FIFO.
//   clk, rst     : clock, synchronous active-high reset
//   rxd          : asynchronous serial input, idle high
//   rx_data      : FIFO head data, LSB = first received bit
//   parity_err   : head entry parity error (valid with rx_valid)
//   frame_err    : head entry stop-bit error (valid with rx_valid)
//   rx_valid     : FIFO not empty
//   rx_ready     : consumer accept, pops when rx_valid && rx_ready
//   overrun      : 1-cycle pulse, completed frame dropped because FIFO full
//   break_det    : 1-cycle pulse, break recognised
//   busy         : FSM not idle
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | line idle, waiting for a falling edge on rxd_s
// ST_START  | validating start bit (vote 1 = glitch, drop back)
// ST_DATA   | shifting in data bits, LSB first
// ST_PARITY | sampling the parity bit
// ST_STOP   | sampling stop bit(s), then push or declare break
// ST_BRK    | break seen, waiting for line to return high
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int BASE_FREQ  = 100_000_000,
  parameter int UART_SPEED = 10_000_000,
  parameter int WORD_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  output logic [WORD_WIDTH-1:0] rx_data,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  overrun,
  output logic                  break_det,
  output logic                  busy
);

  localparam int DIV = BASE_FREQ / UART_SPEED;
  localparam int H   = DIV / 2;
  localparam int CW  = clogb2(DIV);
  localparam int EW  = WORD_WIDTH + 2;
  localparam logic [CW-1:0] C_HM1  = CW'(H - 1);
  localparam logic [CW-1:0] C_H    = CW'(H);
  localparam logic [CW-1:0] C_HP1  = CW'(H + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

  if (DIV < 4) begin : g_chk_div
    $error("uart_rx_cfg: BASE_FREQ/UART_SPEED must be at least 4");
  end
  if (WORD_WIDTH < 5 || WORD_WIDTH > 9) begin : g_chk_width
    $error("uart_rx_cfg: WORD_WIDTH must be 5..9");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_chk_par
    $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end

  rx_state_t             r_state;
  logic                  r_rxd_m, r_rxd_s, r_rxd_d;
  logic [CW-1:0]         r_cnt;
  logic [1:0]            r_smp;
  logic [3:0]            r_bitcnt;
  logic                  r_stop_idx;
  logic [WORD_WIDTH-1:0] r_shift;
  logic                  r_perr, r_ferr, r_par_bit, r_stop_hi;
  logic                  r_push;
  logic [EW-1:0]         r_push_data;
  logic                  r_brk_pulse;
  logic                  r_overrun;

  logic                  w_fall, w_dec, w_vote;
  logic                  w_ferr_n, w_stop_hi_n, w_break;
  logic                  w_full, w_empty, w_pop;
  logic [EW-1:0]         w_head;

  assign w_fall = r_rxd_d & ~r_rxd_s;
  assign w_dec  = (r_state != ST_IDLE) && (r_cnt == C_HP1);
  // third sample is the live value at the decision count
  assign w_vote = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_rxd_s) | (r_smp[1] & r_rxd_s);

  assign w_ferr_n    = r_ferr | ~w_vote;
  assign w_stop_hi_n = r_stop_hi | w_vote;
  // r_par_bit stays 0 without parity, so it never blocks break detection
  assign w_break     = (r_shift == '0) && !r_par_bit && !w_stop_hi_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxd_m     <= 1'b1;
      r_rxd_s     <= 1'b1;
      r_rxd_d     <= 1'b1;
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_smp       <= '0;
      r_bitcnt    <= '0;
      r_stop_idx  <= 1'b0;
      r_shift     <= '0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_par_bit   <= 1'b0;
      r_stop_hi   <= 1'b0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_brk_pulse <= 1'b0;
    end else begin
      r_rxd_m     <= rxd;
      r_rxd_s     <= r_rxd_m;
      r_rxd_d     <= r_rxd_s;
      r_push      <= 1'b0;
      r_brk_pulse <= 1'b0;

      if (r_state != ST_IDLE) r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + CW'(1);
      if (r_cnt == C_HM1) r_smp[0] <= r_rxd_s;
      if (r_cnt == C_H)   r_smp[1] <= r_rxd_s;

      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state    <= ST_START;
            r_cnt      <= '0;
            r_bitcnt   <= '0;
            r_stop_idx <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop_hi  <= 1'b0;
          end
        end
        ST_START: begin
          if (w_dec) begin
            if (w_vote) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_dec) begin
            r_shift <= {w_vote, r_shift[WORD_WIDTH-1:1]};
            if (r_bitcnt == 4'(WORD_WIDTH - 1)) begin
              r_state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (w_dec) begin
            r_par_bit <= w_vote;
            r_perr    <= ((^r_shift) ^ w_vote) != (PARITY == PAR_ODD);
            r_state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_dec) begin
            r_ferr    <= w_ferr_n;
            r_stop_hi <= w_stop_hi_n;
            if (r_stop_idx == 1'(STOP_BITS - 1)) begin
              // leave mid-stop-bit so the next start edge is not missed
              r_cnt <= '0;
              if (w_break) begin
                r_state     <= ST_BRK;
                r_brk_pulse <= 1'b1;
              end else begin
                r_state     <= ST_IDLE;
                r_push      <= 1'b1;
                r_push_data <= {w_ferr_n, r_perr, r_shift};
              end
            end else begin
              r_stop_idx <= 1'b1;
            end
          end
        end
        ST_BRK: begin
          if (r_rxd_s) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign w_pop = rx_ready & ~w_empty;

  always_ff @(posedge clk) begin
    if (rst) r_overrun <= 1'b0;
    else     r_overrun <= r_push & w_full & ~w_pop;
  end

  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (r_push),
    .wr_data (r_push_data),
    .pop     (rx_ready),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign rx_data    = w_head[WORD_WIDTH-1:0];
  assign parity_err = w_head[WORD_WIDTH];
  assign frame_err  = w_head[WORD_WIDTH+1];
  assign rx_valid   = ~w_empty;
  assign overrun    = r_overrun;
  assign break_det  = r_brk_pulse;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1 main instance plus 8E1 and 7O2 instances
// sharing rxd/rst/rx_ready. Inputs change 1 time unit after the rising edge,
// outputs are observed on the falling edge.
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic rx_ready = 1'b1;

  always #5 clk = ~clk;

  logic [7:0] rx_data;
  logic       parity_err, frame_err, rx_valid, overrun, break_det, busy;
  logic [7:0] rx_data_e;
  logic       parity_err_e, frame_err_e, rx_valid_e, overrun_e, break_det_e, busy_e;
  logic [6:0] rx_data_o;
  logic       parity_err_o, frame_err_o, rx_valid_o, overrun_o, break_det_o, busy_o;

  uart_rx_cfg #(.BASE_FREQ(100_000_000), .UART_SPEED(10_000_000), .WORD_WIDTH(8),
                .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rx_data(rx_data), .parity_err(parity_err),
    .frame_err(frame_err), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .break_det(break_det), .busy(busy));

  uart_rx_cfg #(.BASE_FREQ(100_000_000), .UART_SPEED(10_000_000), .WORD_WIDTH(8),
                .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_e (
    .clk(clk), .rst(rst), .rxd(rxd), .rx_data(rx_data_e), .parity_err(parity_err_e),
    .frame_err(frame_err_e), .rx_valid(rx_valid_e), .rx_ready(rx_ready),
    .overrun(overrun_e), .break_det(break_det_e), .busy(busy_e));

  uart_rx_cfg #(.BASE_FREQ(100_000_000), .UART_SPEED(10_000_000), .WORD_WIDTH(7),
                .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_o (
    .clk(clk), .rst(rst), .rxd(rxd), .rx_data(rx_data_o), .parity_err(parity_err_o),
    .frame_err(frame_err_o), .rx_valid(rx_valid_o), .rx_ready(rx_ready),
    .overrun(overrun_o), .break_det(break_det_o), .busy(busy_o));

  int n_chk = 0;
  int n_fail = 0;
  int pcyc = 0;
  int t_start = 0;
  int t_valid = 0;
  int n_ovr = 0, n_brk = 0, n_busy = 0;
  int n_pop_e = 0, n_pop_o = 0, n_side = 0;
  logic prev_valid = 1'b0;
  logic [9:0] q[$];
  logic [9:0] last_e = '0;
  logic [8:0] last_o = '0;

  always @(posedge clk) pcyc++;

  always @(negedge clk) begin
    if (overrun)   n_ovr++;
    if (break_det) n_brk++;
    if (busy)      n_busy++;
    if (rx_valid && !prev_valid) t_valid = pcyc;
    prev_valid = rx_valid;
    if (rx_valid && rx_ready) q.push_back({frame_err, parity_err, rx_data});
    if (rx_valid_e && rx_ready) begin
      n_pop_e++;
      last_e = {frame_err_e, parity_err_e, rx_data_e};
    end
    if (rx_valid_o && rx_ready) begin
      n_pop_o++;
      last_o = {frame_err_o, parity_err_o, rx_data_o};
    end
    if (overrun_e || break_det_e || overrun_o || break_det_o) n_side++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] b, input int n);
    t_start = pcyc;
    for (int i = 0; i < n; i++) begin
      rxd = b[i];
      wait_clk(10);
    end
    rxd = 1'b1;
  endtask

  function automatic logic [15:0] f8n1(input logic [7:0] d, input logic s);
    return {6'b0, s, d, 1'b0};
  endfunction

  task automatic pulse_rst();
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(3);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       exp_push;
    logic       exp_fe;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int b_ovr, b_brk, b_busy, b_pe, b_po, b_side;

    tbl[0] = '{d: 8'hA5, stop: 1'b1, exp_push: 1'b1, exp_fe: 1'b0};
    tbl[1] = '{d: 8'h81, stop: 1'b0, exp_push: 1'b1, exp_fe: 1'b1};
    tbl[2] = '{d: 8'h00, stop: 1'b1, exp_push: 1'b1, exp_fe: 1'b0};
    tbl[3] = '{d: 8'hFF, stop: 1'b1, exp_push: 1'b1, exp_fe: 1'b0};
    tbl[4] = '{d: 8'h00, stop: 1'b0, exp_push: 1'b0, exp_fe: 1'b0};
    tbl[5] = '{d: 8'hC3, stop: 1'b1, exp_push: 1'b1, exp_fe: 1'b0};

    // reset state
    wait_clk(4);
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_break", 32'(break_det), 0);
    chk("rst_data", 32'({frame_err, parity_err, rx_data}), 0);
    rst = 1'b0;
    wait_clk(5);

    // 8N1 vectors
    for (int i = 0; i < 6; i++) begin
      b_ovr = n_ovr;
      b_brk = n_brk;
      q.delete();
      send_bits(f8n1(tbl[i].d, tbl[i].stop), 10);
      wait_clk(30);
      chk("vec_push_count", 32'(q.size()), 32'(tbl[i].exp_push));
      if (tbl[i].exp_push && q.size() > 0) begin
        chk("vec_data", 32'(q[0][7:0]), 32'(tbl[i].d));
        chk("vec_frame_err", 32'(q[0][9]), 32'(tbl[i].exp_fe));
        chk("vec_parity_err", 32'(q[0][8]), 0);
      end
      chk("vec_break", 32'(n_brk - b_brk), 32'(!tbl[i].exp_push));
      chk("vec_overrun", 32'(n_ovr - b_ovr), 0);
      if (i == 0) chk("latency_start_to_valid", 32'(t_valid - t_start), 101);
    end

    // start glitch
    q.delete();
    b_busy = n_busy;
    rxd = 1'b0;
    wait_clk(3);
    rxd = 1'b1;
    wait_clk(8);
    chk("glitch_busy_cleared", 32'(busy), 0);
    chk("glitch_busy_seen", 32'(n_busy != b_busy), 1);
    wait_clk(20);
    chk("glitch_no_push", 32'(q.size()), 0);

    // long break, then a normal frame
    b_brk = n_brk;
    rxd = 1'b0;
    wait_clk(200);
    chk("break_pulses", 32'(n_brk - b_brk), 1);
    chk("break_busy", 32'(busy), 1);
    chk("break_no_valid", 32'(rx_valid), 0);
    chk("break_no_push", 32'(q.size()), 0);
    rxd = 1'b1;
    wait_clk(5);
    chk("break_busy_released", 32'(busy), 0);
    send_bits(f8n1(8'h12, 1'b1), 10);
    wait_clk(30);
    chk("after_break_count", 32'(q.size()), 1);
    if (q.size() > 0) chk("after_break_data", 32'(q[0]), 32'h012);

    // overrun: five frames back-to-back into a 4-deep FIFO
    q.delete();
    rx_ready = 1'b0;
    b_ovr = n_ovr;
    for (int k = 1; k <= 5; k++) send_bits(f8n1(8'(k), 1'b1), 10);
    wait_clk(20);
    chk("overrun_pulses", 32'(n_ovr - b_ovr), 1);
    chk("overrun_no_pop", 32'(q.size()), 0);
    rx_ready = 1'b1;
    wait_clk(10);
    chk("drain_count", 32'(q.size()), 4);
    for (int j = 0; j < 4 && j < q.size(); j++) chk("drain_data", 32'(q[j]), 32'(j + 1));
    chk("drain_empty", 32'(rx_valid), 0);

    // push and pop in the same cycle while full
    q.delete();
    rx_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_bits(f8n1(8'h11 + 8'(k), 1'b1), 10);
    wait_clk(20);
    b_ovr = n_ovr;
    fork
      send_bits(f8n1(8'h15, 1'b1), 10);
      begin
        wait_clk(100);
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
      end
    join
    wait_clk(20);
    chk("pushpop_no_overrun", 32'(n_ovr - b_ovr), 0);
    chk("pushpop_one_pop", 32'(q.size()), 1);
    rx_ready = 1'b1;
    wait_clk(10);
    chk("pushpop_total", 32'(q.size()), 5);
    if (q.size() == 5) begin
      chk("pushpop_head", 32'(q[0]), 32'h011);
      chk("pushpop_tail", 32'(q[4]), 32'h015);
    end

    // reset in the middle of a frame
    q.delete();
    fork
      send_bits(f8n1(8'hFF, 1'b1), 10);
      begin
        wait_clk(45);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
      end
    join
    wait_clk(20);
    chk("midrst_no_push", 32'(q.size()), 0);
    send_bits(f8n1(8'h5A, 1'b1), 10);
    wait_clk(30);
    chk("midrst_next_count", 32'(q.size()), 1);
    if (q.size() > 0) chk("midrst_next_data", 32'(q[0]), 32'h05A);

    // parity configurations
    pulse_rst();
    b_side = n_side;
    b_pe = n_pop_e;
    send_bits({5'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
    wait_clk(30);
    chk("8e1_bad_count", 32'(n_pop_e - b_pe), 1);
    chk("8e1_bad_entry", 32'(last_e), {22'b0, 2'b01, 8'h3C});
    b_pe = n_pop_e;
    send_bits({5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11);
    wait_clk(30);
    chk("8e1_good_count", 32'(n_pop_e - b_pe), 1);
    chk("8e1_good_entry", 32'(last_e), {22'b0, 2'b00, 8'h3C});

    b_po = n_pop_o;
    send_bits({5'b0, 1'b1, 1'b1, 1'b1, 7'h55, 1'b0}, 11);
    wait_clk(30);
    chk("7o2_good_count", 32'(n_pop_o - b_po), 1);
    chk("7o2_good_entry", 32'(last_o), {23'b0, 2'b00, 7'h55});
    b_po = n_pop_o;
    send_bits({5'b0, 1'b0, 1'b1, 1'b1, 7'h55, 1'b0}, 11);
    wait_clk(30);
    chk("7o2_stop2_count", 32'(n_pop_o - b_po), 1);
    chk("7o2_stop2_entry", 32'(last_o), {23'b0, 2'b10, 7'h55});
    b_po = n_pop_o;
    send_bits({5'b0, 1'b1, 1'b1, 1'b0, 7'h3C, 1'b0}, 11);
    wait_clk(30);
    chk("7o2_bad_count", 32'(n_pop_o - b_po), 1);
    chk("7o2_bad_entry", 32'(last_o), {23'b0, 2'b01, 7'h3C});
    chk("parity_units_no_pulses", 32'(n_side - b_side), 0);
    chk("parity_units_idle", 32'({busy_e, busy_o}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
